// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//
// Sequences repeated image acquisitions on the ultrasound transmit path. Each
// frame is launched with a one-cycle start_transmit pulse. Every captured
// A-line is then read out and its buffer cleared. Successive launches are
// spaced by at least the programmed frame period. The run ends after the
// programmed frame count, on a stop request, or on a watchdog timeout.
//
// Parameters
//   TIMEOUT_CYCLES    watchdog limit for WAIT_ACCEPT and READOUT
//   SETTLE_CYCLES     cycles after ACQUIRE entry during which the
//                     xmit_in_progress drop is ignored
//
// Ports
//   clk               system clock, all logic on the rising edge
//   rst               synchronous active-low reset
//   seq_start         one-cycle pulse: latch config and begin a sequence
//   stop_req          level: finish the current frame, then stop
//   frame_count_cfg   frames per sequence, 0 = continuous
//   frame_period_cfg  minimum clocks between start_transmit pulses
//   xmit_busy         transmit FSM busy
//   xmit_in_progress  transmit FSM frame active
//   aline_captured    pulse: A-line data is in the capture buffer
//   rd_done           pulse: readout drained the buffer
//   start_transmit    one-cycle launch pulse to the transmit FSM
//   rd_req            level readout request while in READOUT
//   mem_clear         one-cycle buffer clear pulse
//   aline_idx         A-line index within the current frame
//   frames_done       completed frames in the current sequence
//   seq_active        high from ARM through PERIOD_WAIT
//   seq_done          one-cycle pulse on normal completion
//   timeout_err       sticky watchdog error
// -----------------------------------------------------------------------------
module frame_sequencer #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000,
    parameter int unsigned SETTLE_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seq_start,
    input  logic        stop_req,
    input  logic [15:0] frame_count_cfg,
    input  logic [23:0] frame_period_cfg,
    input  logic        xmit_busy,
    input  logic        xmit_in_progress,
    input  logic        aline_captured,
    input  logic        rd_done,
    output logic        start_transmit,
    output logic        rd_req,
    output logic        mem_clear,
    output logic [3:0]  aline_idx,
    output logic [15:0] frames_done,
    output logic        seq_active,
    output logic        seq_done,
    output logic        timeout_err
);

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_ARM         = 4'd1,
        ST_LAUNCH      = 4'd2,
        ST_WAIT_ACCEPT = 4'd3,
        ST_ACQUIRE     = 4'd4,
        ST_READOUT     = 4'd5,
        ST_CLEAR       = 4'd6,
        ST_FRAME_END   = 4'd7,
        ST_PERIOD_WAIT = 4'd8,
        ST_DONE        = 4'd9,
        ST_ERROR       = 4'd10
    } state_t;

    localparam logic [7:0] SETTLE_LIM = 8'(SETTLE_CYCLES);

    state_t      state_q,          state_d;
    logic [15:0] count_cfg_q,      count_cfg_d;
    logic [23:0] period_cfg_q,     period_cfg_d;
    logic [23:0] period_cnt_q,     period_cnt_d;
    logic [23:0] wdog_q,           wdog_d;
    logic [7:0]  settle_q,         settle_d;
    logic [3:0]  aline_idx_q,      aline_idx_d;
    logic [15:0] frames_done_q,    frames_done_d;
    logic        timeout_err_q,    timeout_err_d;
    logic        start_transmit_q, start_transmit_d;
    logic        rd_req_q,         rd_req_d;
    logic        mem_clear_q,      mem_clear_d;
    logic        seq_active_q,     seq_active_d;
    logic        seq_done_q,       seq_done_d;

    logic [23:0] wdog_inc_s;
    logic        period_elapsed_s;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d       = state_q;
        count_cfg_d   = count_cfg_q;
        period_cfg_d  = period_cfg_q;
        wdog_d        = wdog_q;
        aline_idx_d   = aline_idx_q;
        frames_done_d = frames_done_q;
        timeout_err_d = timeout_err_q;

        // Free-running saturating counters; they are zeroed on the
        // transitions that give them meaning.
        if (period_cnt_q == 24'hFF_FFFF) begin
            period_cnt_d = period_cnt_q;
        end else begin
            period_cnt_d = period_cnt_q + 24'd1;
        end
        if (settle_q == 8'hFF) begin
            settle_d = settle_q;
        end else begin
            settle_d = settle_q + 8'd1;
        end
        if (wdog_q == 24'hFF_FFFF) begin
            wdog_inc_s = wdog_q;
        end else begin
            wdog_inc_s = wdog_q + 24'd1;
        end

        // Leaving PERIOD_WAIT when the counter reaches period-2 leaves
        // exactly ARM and LAUNCH to complete the period. Evaluated in 25
        // bits so that periods below 2 do not wrap.
        period_elapsed_s = (({1'b0, period_cnt_q} + 25'd2) >= {1'b0, period_cfg_q});

        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (seq_start) begin
                    count_cfg_d   = frame_count_cfg;
                    period_cfg_d  = frame_period_cfg;
                    frames_done_d = 16'd0;
                    timeout_err_d = 1'b0;
                    state_d       = ST_ARM;
                end else begin
                    state_d = state_q;
                end
            end
            ST_ARM: begin
                if (!xmit_busy) begin
                    state_d      = ST_LAUNCH;
                    aline_idx_d  = 4'd0;
                    period_cnt_d = 24'd0;
                    wdog_d       = 24'd0;
                end else begin
                    state_d = ST_ARM;
                end
            end
            ST_LAUNCH: begin
                // The watchdog counts cycles since the launch.
                wdog_d  = wdog_inc_s;
                state_d = ST_WAIT_ACCEPT;
            end
            ST_WAIT_ACCEPT: begin
                if (xmit_in_progress) begin
                    settle_d = 8'd0;
                    state_d  = ST_ACQUIRE;
                end else if (wdog_inc_s == TIMEOUT_CYCLES) begin
                    wdog_d        = wdog_inc_s;
                    timeout_err_d = 1'b1;
                    state_d       = ST_ERROR;
                end else begin
                    wdog_d = wdog_inc_s;
                end
            end
            ST_ACQUIRE: begin
                // A capture takes priority over a simultaneous frame end.
                if (aline_captured) begin
                    wdog_d  = 24'd0;
                    state_d = ST_READOUT;
                end else if ((settle_q >= SETTLE_LIM) && !xmit_in_progress) begin
                    if (frames_done_q == 16'hFFFF) begin
                        frames_done_d = frames_done_q;
                    end else begin
                        frames_done_d = frames_done_q + 16'd1;
                    end
                    state_d = ST_FRAME_END;
                end else begin
                    state_d = ST_ACQUIRE;
                end
            end
            ST_READOUT: begin
                if (rd_done) begin
                    aline_idx_d = aline_idx_q + 4'd1;
                    state_d     = ST_CLEAR;
                end else if (wdog_inc_s == TIMEOUT_CYCLES) begin
                    wdog_d        = wdog_inc_s;
                    timeout_err_d = 1'b1;
                    state_d       = ST_ERROR;
                end else begin
                    wdog_d = wdog_inc_s;
                end
            end
            ST_CLEAR: begin
                settle_d = 8'd0;
                state_d  = ST_ACQUIRE;
            end
            ST_FRAME_END: begin
                // frames_done_q already holds the incremented count here.
                if (stop_req || ((count_cfg_q != 16'd0) && (frames_done_q == count_cfg_q))) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_PERIOD_WAIT;
                end
            end
            ST_PERIOD_WAIT: begin
                if (stop_req) begin
                    state_d = ST_DONE;
                end else if (period_elapsed_s) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_PERIOD_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Moore outputs decoded from the next state so they rise on the
        // same edge that enters the state.
        start_transmit_d = (state_d == ST_LAUNCH);
        rd_req_d         = (state_d == ST_READOUT);
        mem_clear_d      = (state_d == ST_CLEAR);
        seq_done_d       = (state_d == ST_DONE);
        seq_active_d     = (state_d == ST_ARM)         || (state_d == ST_LAUNCH)  ||
                           (state_d == ST_WAIT_ACCEPT) || (state_d == ST_ACQUIRE) ||
                           (state_d == ST_READOUT)     || (state_d == ST_CLEAR)   ||
                           (state_d == ST_FRAME_END)   || (state_d == ST_PERIOD_WAIT);
    end

    // State, counters, latched config and outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            count_cfg_q      <= 16'd0;
            period_cfg_q     <= 24'd0;
            period_cnt_q     <= 24'd0;
            wdog_q           <= 24'd0;
            settle_q         <= 8'd0;
            aline_idx_q      <= 4'd0;
            frames_done_q    <= 16'd0;
            timeout_err_q    <= 1'b0;
            start_transmit_q <= 1'b0;
            rd_req_q         <= 1'b0;
            mem_clear_q      <= 1'b0;
            seq_active_q     <= 1'b0;
            seq_done_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_cfg_q      <= count_cfg_d;
            period_cfg_q     <= period_cfg_d;
            period_cnt_q     <= period_cnt_d;
            wdog_q           <= wdog_d;
            settle_q         <= settle_d;
            aline_idx_q      <= aline_idx_d;
            frames_done_q    <= frames_done_d;
            timeout_err_q    <= timeout_err_d;
            start_transmit_q <= start_transmit_d;
            rd_req_q         <= rd_req_d;
            mem_clear_q      <= mem_clear_d;
            seq_active_q     <= seq_active_d;
            seq_done_q       <= seq_done_d;
        end
    end

    assign start_transmit = start_transmit_q;
    assign rd_req         = rd_req_q;
    assign mem_clear      = mem_clear_q;
    assign aline_idx      = aline_idx_q;
    assign frames_done    = frames_done_q;
    assign seq_active     = seq_active_q;
    assign seq_done       = seq_done_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_sequencer
//
// Directed bench for frame_sequencer. A behavioural transmit/capture model
// answers launches and readout requests. Expected launch times, A-line
// indices and mem_clear times go into scoreboard queues when the stimulus
// that causes them is driven. A monitor pops and compares them when the DUT
// produces the corresponding output.
// -----------------------------------------------------------------------------
module tb_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        seq_start = 1'b0;
    logic        stop_req = 1'b0;
    logic [15:0] frame_count_cfg = 16'd0;
    logic [23:0] frame_period_cfg = 24'd0;
    logic        xmit_busy = 1'b0;
    logic        xmit_in_progress = 1'b0;
    logic        aline_captured = 1'b0;
    logic        rd_done = 1'b0;
    logic        start_transmit;
    logic        rd_req;
    logic        mem_clear;
    logic [3:0]  aline_idx;
    logic [15:0] frames_done;
    logic        seq_active;
    logic        seq_done;
    logic        timeout_err;

    frame_sequencer #(
        .TIMEOUT_CYCLES (24'd50),
        .SETTLE_CYCLES  (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .seq_start        (seq_start),
        .stop_req         (stop_req),
        .frame_count_cfg  (frame_count_cfg),
        .frame_period_cfg (frame_period_cfg),
        .xmit_busy        (xmit_busy),
        .xmit_in_progress (xmit_in_progress),
        .aline_captured   (aline_captured),
        .rd_done          (rd_done),
        .start_transmit   (start_transmit),
        .rd_req           (rd_req),
        .mem_clear        (mem_clear),
        .aline_idx        (aline_idx),
        .frames_done      (frames_done),
        .seq_active       (seq_active),
        .seq_done         (seq_done),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Transmit model knobs
    int n_alines = 3;
    int gap      = 3;
    int tail     = 4;
    int rd_lat   = 5;
    bit accept_en = 1'b1;
    int relaunch_pushes = 0;

    // Scoreboards
    int exp_launch[$];
    int exp_idx[$];
    int exp_clr[$];
    bit chk_launch_time = 1'b0;

    // Monitor counters
    int n_launch = 0;
    int n_clear  = 0;
    int n_done   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        seq_start = 1'b1;
        @(negedge clk);
        seq_start = 1'b0;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!seq_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(seq_done), 32'd1);
    endtask

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Image transmit FSM + capture + readout behavioural model.
    initial begin : xmit_model
        forever begin
            @(negedge clk);
            if (start_transmit && accept_en) begin
                xmit_in_progress = 1'b1;
                for (int a = 0; a < n_alines; a++) begin
                    repeat (gap) @(negedge clk);
                    aline_captured = 1'b1;
                    exp_idx.push_back(a);
                    @(negedge clk);
                    aline_captured = 1'b0;
                    for (int k = 0; k < 50 && !rd_req; k++) @(negedge clk);
                    repeat (rd_lat - 1) @(negedge clk);
                    rd_done = 1'b1;
                    if (rd_req) exp_clr.push_back(cyc + 1);
                    @(negedge clk);
                    rd_done = 1'b0;
                end
                repeat (tail) @(negedge clk);
                xmit_in_progress = 1'b0;
                // ACQUIRE sees the drop this cycle: FRAME_END, PERIOD_WAIT,
                // ARM, then LAUNCH four cycles later when the period is short.
                if (relaunch_pushes > 0) begin
                    exp_launch.push_back(cyc + 4);
                    relaunch_pushes--;
                end
            end
        end
    end

    // Output monitor: pops scoreboards when the DUT produces events.
    initial begin : monitor
        logic prev_rd_req;
        int   e;
        prev_rd_req = 1'b0;
        forever begin
            @(negedge clk);
            if (start_transmit) begin
                n_launch++;
                if (chk_launch_time) begin
                    chk("launch_queued", 32'(exp_launch.size() != 0), 32'd1);
                    if (exp_launch.size() != 0) begin
                        e = exp_launch.pop_front();
                        chk("launch_cycle", 32'(cyc), 32'(e));
                    end
                end
            end
            if (rd_req && !prev_rd_req) begin
                chk("idx_queued", 32'(exp_idx.size() != 0), 32'd1);
                if (exp_idx.size() != 0) begin
                    e = exp_idx.pop_front();
                    chk("aline_idx", 32'(aline_idx), 32'(e));
                end
            end
            if (mem_clear) begin
                n_clear++;
                chk("clr_queued", 32'(exp_clr.size() != 0), 32'd1);
                if (exp_clr.size() != 0) begin
                    e = exp_clr.pop_front();
                    chk("mem_clear_cycle", 32'(cyc), 32'(e));
                end
            end
            if (seq_done) n_done++;
            prev_rd_req = rd_req;
        end
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int c, l0, m0, d0, nl, k;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_flags", {28'd0, start_transmit, rd_req, mem_clear, seq_done}, 32'd0);
        chk("rst_status", {30'd0, seq_active, timeout_err}, 32'd0);
        chk("rst_aline_idx", 32'(aline_idx), 32'd0);
        chk("rst_frames_done", 32'(frames_done), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // ---------------- basic sequence ----------------
        frame_count_cfg = 16'd2; frame_period_cfg = 24'd100;
        n_alines = 3; gap = 3; tail = 4; rd_lat = 5;
        chk_launch_time = 1'b1;
        c = cyc; l0 = n_launch; m0 = n_clear; d0 = n_done;
        exp_launch.push_back(c + 2);
        exp_launch.push_back(c + 102);
        pulse_start();
        repeat (28) @(negedge clk);
        chk("t1_active_before_restart", 32'(seq_active), 32'd1);
        pulse_start();                      // must be ignored
        wait_done("t1_seq_done", 600);
        chk("t1_frames_done", 32'(frames_done), 32'd2);
        repeat (5) @(negedge clk);
        chk("t1_launches", 32'(n_launch - l0), 32'd2);
        chk("t1_mem_clears", 32'(n_clear - m0), 32'd6);
        chk("t1_done_pulses", 32'(n_done - d0), 32'd1);
        chk("t1_inactive", 32'(seq_active), 32'd0);
        chk("t1_sb_empty", 32'(exp_launch.size() + exp_idx.size() + exp_clr.size()), 32'd0);

        // ---------------- long frame vs short period ----------------
        frame_count_cfg = 16'd2; frame_period_cfg = 24'd10;
        n_alines = 1; gap = 180; tail = 10; rd_lat = 5;
        relaunch_pushes = 1;
        c = cyc; l0 = n_launch;
        exp_launch.push_back(c + 2);
        pulse_start();
        wait_done("t2_seq_done", 1000);
        chk("t2_frames_done", 32'(frames_done), 32'd2);
        chk("t2_launches", 32'(n_launch - l0), 32'd2);
        chk("t2_sb_empty", 32'(exp_launch.size() + exp_idx.size() + exp_clr.size()), 32'd0);
        repeat (3) @(negedge clk);

        // ---------------- continuous with stop ----------------
        frame_count_cfg = 16'd0; frame_period_cfg = 24'd0;
        n_alines = 1; gap = 3; tail = 4; rd_lat = 5;
        chk_launch_time = 1'b0;
        l0 = n_launch; d0 = n_done;
        pulse_start();
        nl = 0; k = 0;
        while (nl < 3 && k < 300) begin
            @(negedge clk);
            if (start_transmit) nl++;
            k++;
        end
        chk("t3_three_launches", 32'(nl), 32'd3);
        stop_req = 1'b1;
        wait_done("t3_seq_done", 300);
        stop_req = 1'b0;
        chk("t3_frames_done", 32'(frames_done), 32'd3);
        repeat (20) @(negedge clk);
        chk("t3_no_fourth_launch", 32'(n_launch - l0), 32'd3);
        chk("t3_done_pulses", 32'(n_done - d0), 32'd1);
        chk("t3_sb_empty", 32'(exp_idx.size() + exp_clr.size()), 32'd0);

        // ---------------- accept timeout ----------------
        accept_en = 1'b0;
        frame_count_cfg = 16'd1; frame_period_cfg = 24'd0;
        chk_launch_time = 1'b1;
        c = cyc;
        exp_launch.push_back(c + 2);
        pulse_start();
        wait_to(c + 2 + 49);
        chk("t4_no_err_at_49", 32'(timeout_err), 32'd0);
        chk("t4_active_at_49", 32'(seq_active), 32'd1);
        @(negedge clk);
        chk("t4_err_at_50", 32'(timeout_err), 32'd1);
        chk("t4_inactive_at_50", 32'(seq_active), 32'd0);
        repeat (10) @(negedge clk);
        chk("t4_err_sticky", 32'(timeout_err), 32'd1);
        accept_en = 1'b1;
        c = cyc; d0 = n_done;
        exp_launch.push_back(c + 2);
        pulse_start();
        chk("t4_err_cleared", 32'(timeout_err), 32'd0);
        wait_done("t4_seq_done", 300);
        chk("t4_frames_done", 32'(frames_done), 32'd1);
        chk("t4_sb_empty", 32'(exp_launch.size() + exp_idx.size() + exp_clr.size()), 32'd0);
        repeat (3) @(negedge clk);

        // ---------------- start gated by busy ----------------
        frame_count_cfg = 16'd1;
        c = cyc; l0 = n_launch;
        xmit_busy = 1'b1;
        exp_launch.push_back(c + 21);
        pulse_start();
        wait_to(c + 20);
        chk("t5_no_early_launch", 32'(n_launch - l0), 32'd0);
        xmit_busy = 1'b0;
        wait_done("t5_seq_done", 300);
        chk("t5_launches", 32'(n_launch - l0), 32'd1);
        chk("t5_sb_empty", 32'(exp_launch.size()), 32'd0);
        repeat (3) @(negedge clk);

        // ---------------- reset during READOUT ----------------
        frame_count_cfg = 16'd0;
        n_alines = 2; gap = 3; tail = 4; rd_lat = 20;
        chk_launch_time = 1'b0;
        d0 = n_done;
        pulse_start();
        k = 0;
        while (!(rd_req && aline_idx == 4'd1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t6_in_second_readout", 32'(rd_req), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_flags", {28'd0, start_transmit, rd_req, mem_clear, seq_done}, 32'd0);
        chk("t6_rst_status", {30'd0, seq_active, timeout_err}, 32'd0);
        chk("t6_rst_aline_idx", 32'(aline_idx), 32'd0);
        chk("t6_rst_frames_done", 32'(frames_done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        chk("t6_no_seq_done", 32'(n_done - d0), 32'd0);
        chk("t6_idle", 32'(seq_active), 32'd0);
        chk("t6_sb_empty", 32'(exp_idx.size() + exp_clr.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
